// File: rtl/key_array_debounce.sv
// key_array_debounce: N-channel key front end (sync, symmetric debounce, press/release/long pulses).
// Optional auto-repeat is compiled in when the KEY_REPEAT_EN macro is defined.
module key_array_debounce #(
   parameter int NUM_KEYS     = 4,
   parameter int ACTIVE_LOW   = 1,
   parameter int DEBOUNCE_CNT = 540000,
   parameter int LONG_CNT     = 27000000,
   parameter int REPEAT_CNT   = 5400000
) (
   input  logic                sys_clk,
   input  logic                rst_in,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_state,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                key_any_press
);

   localparam logic            REL_LVL   = (ACTIVE_LOW != 0);
   localparam int              DW        = $clog2(DEBOUNCE_CNT);
   localparam int              HW        = $clog2(LONG_CNT + 1);
   localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(LONG_CNT - 1);
   localparam logic [HW-1:0]   HOLD_MAX  = HW'(LONG_CNT);

   if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CNT < 2 || LONG_CNT < 2 || REPEAT_CNT < 1)
   begin : g_param_check
      $error("key_array_debounce: parameter out of range");
   end

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;
   logic [NUM_KEYS-1:0] lvl;
   logic [NUM_KEYS-1:0] press_nxt;

   // Sync flops reset to the released level so leaving reset never looks like an edge.
   always_ff @(posedge sys_clk or negedge rst_in) begin
      if (!rst_in) begin
         sync1 <= {NUM_KEYS{REL_LVL}};
         sync2 <= {NUM_KEYS{REL_LVL}};
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign lvl = sync2 ^ {NUM_KEYS{REL_LVL}};

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic [DW-1:0] deb_cnt;
      logic [HW-1:0] hold_cnt;
      logic          state_q;
      logic          press_q;
      logic          release_q;
      logic          long_q;
      logic          differ;
      logic          accept;
      logic          releasing;
      logic          long_fire;

      assign differ       = lvl[i] ^ state_q;
      assign accept       = differ && (deb_cnt == DEB_LAST);
      assign releasing    = accept && !lvl[i];
      assign press_nxt[i] = accept && lvl[i];
      // A long press landing on the release edge is dropped: no pulse beside a released level.
      assign long_fire    = state_q && !releasing && (hold_cnt == HOLD_LAST);

      always_ff @(posedge sys_clk or negedge rst_in) begin
         if (!rst_in) begin
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            if (!differ) begin
               deb_cnt <= '0;
            end else if (accept) begin
               deb_cnt <= '0;
               state_q <= lvl[i];
            end else begin
               deb_cnt <= deb_cnt + 1'b1;
            end

            press_q   <= press_nxt[i];
            release_q <= releasing;
            long_q    <= long_fire;

            if (!state_q) begin
               hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end

      assign key_state[i]   = state_q;
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;

`ifdef KEY_REPEAT_EN
      localparam int            RW       = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
      localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);

      logic [RW-1:0] rep_cnt;
      logic          rep_q;

      // Repeat phase starts at the long-press cycle; hold_cnt saturated marks "past long press".
      always_ff @(posedge sys_clk or negedge rst_in) begin
         if (!rst_in) begin
            rep_cnt <= '0;
            rep_q   <= 1'b0;
         end else begin
            rep_q <= 1'b0;
            if (!state_q || releasing || long_fire) begin
               rep_cnt <= '0;
            end else if (hold_cnt == HOLD_MAX) begin
               if (rep_cnt == REP_LAST) begin
                  rep_cnt <= '0;
                  rep_q   <= 1'b1;
               end else begin
                  rep_cnt <= rep_cnt + 1'b1;
               end
            end
         end
      end

      assign key_repeat[i] = rep_q;
`else
      assign key_repeat[i] = 1'b0;
`endif
   end

   always_ff @(posedge sys_clk or negedge rst_in) begin
      if (!rst_in) begin
         key_any_press <= 1'b0;
      end else begin
         key_any_press <= |press_nxt;
      end
   end

endmodule

// File: tb/tb_key_array_debounce.sv
// Bench for key_array_debounce: event scoreboard (kind/key/cycle) plus per-scenario level checks.
module tb_key_array_debounce;

   localparam int NK = 4;
   localparam int W  = 24;
`ifdef KEY_REPEAT_EN
   localparam logic [NK-1:0] REP_AT_FIRST = 4'b0100;
`else
   localparam logic [NK-1:0] REP_AT_FIRST = 4'b0000;
`endif

   logic          sys_clk = 1'b0;
   logic          rst_in  = 1'b0;
   logic [NK-1:0] key_raw = '1;
   logic [NK-1:0] key_state;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_long;
   logic [NK-1:0] key_repeat;
   logic          key_any_press;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   // Event word: {kind, key, cycle}; kind 1 press, 2 release, 3 long, 4 repeat, 5 any_press.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_obs[$];
   logic [W-1:0] mon_want;
   logic [3:0]   mon_flags;

   key_array_debounce #(
      .NUM_KEYS    (NK),
      .ACTIVE_LOW  (1),
      .DEBOUNCE_CNT(8),
      .LONG_CNT    (32),
      .REPEAT_CNT  (10)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_in       (rst_in),
      .key_raw      (key_raw),
      .key_state    (key_state),
      .key_press    (key_press),
      .key_release  (key_release),
      .key_long     (key_long),
      .key_repeat   (key_repeat),
      .key_any_press(key_any_press)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] ev(input int kind, input int key, input int c);
      ev = {4'(kind), 4'(key), 16'(c)};
   endfunction

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge sys_clk);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge sys_clk) begin
      if (rst_in) begin
         mon_obs.delete();
         for (int k = 0; k < NK; k++) begin
            mon_flags = {key_repeat[k], key_long[k], key_release[k], key_press[k]};
            for (int j = 0; j < 4; j++)
               if (mon_flags[j]) mon_obs.push_back(ev(j + 1, k, cyc));
         end
         if (key_any_press) mon_obs.push_back(ev(5, 0, cyc));
         foreach (mon_obs[n]) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got event %h, required no event", mon_obs[n]);
            end else begin
               mon_want = exp_q.pop_front();
               if (mon_obs[n] !== mon_want) begin
                  errors++;
                  $display("FAIL sb_event: got %h, required %h", mon_obs[n], mon_want);
               end
            end
         end
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int p;
      rst_in  = 1'b0;
      key_raw = '1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if ({key_state, key_press, key_release, key_long, key_repeat, key_any_press} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b, required all 0",
                  key_state, key_press, key_release, key_long, key_repeat, key_any_press);
      end
      rst_in = 1'b1;
      p = cyc;
      wait_until(p + 12);
      checks++;
      if (key_state !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle_state: got %b, required 0000", key_state);
      end
   endtask

   task automatic test_press();
      int p;
      p = cyc;
      key_raw[0] = 1'b0;
      exp_q.push_back(ev(1, 0, p + 10));
      exp_q.push_back(ev(5, 0, p + 10));
      wait_until(p + 9);
      checks++;
      if (key_state !== 4'b0000) begin
         errors++;
         $display("FAIL press_early: got key_state %b, required 0000", key_state);
      end
      wait_until(p + 10);
      checks++;
      if (key_state !== 4'b0001) begin
         errors++;
         $display("FAIL press_state: got %b, required 0001", key_state);
      end
      checks++;
      if ({key_press, key_any_press} !== 5'b0001_1) begin
         errors++;
         $display("FAIL press_pulse: got %b/%b, required 0001/1", key_press, key_any_press);
      end
      wait_until(p + 11);
      checks++;
      if ({key_press, key_any_press} !== 5'b0) begin
         errors++;
         $display("FAIL press_one_cycle: got %b/%b, required 0000/0", key_press, key_any_press);
      end
      wait_until(p + 14);
      key_raw[0] = 1'b1;
      exp_q.push_back(ev(2, 0, p + 24));
      wait_until(p + 24);
      checks++;
      if (key_state !== 4'b0000 || key_release !== 4'b0001) begin
         errors++;
         $display("FAIL press_release: got state %b rel %b, required 0000/0001", key_state, key_release);
      end
      wait_until(p + 30);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL press_pending: got %0d unseen events (next %h), required 0", exp_q.size(), exp_q[0]);
         exp_q.delete();
      end
   endtask

   task automatic test_bounce();
      int bad;
      bad = 0;
      for (int t = 0; t < 30; t++) begin
         key_raw[1] = !((t < 5) || (t >= 6 && t < 11));
         @(negedge sys_clk);
         if (key_state[1] !== 1'b0 || key_press[1] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bounce_quiet: got %0d active cycles, required 0", bad);
      end
   endtask

   task automatic test_threshold();
      int p;
      p = cyc;
      key_raw[3] = 1'b0;
      wait_until(p + 7);
      key_raw[3] = 1'b1;
      wait_until(p + 20);
      checks++;
      if (key_state[3] !== 1'b0) begin
         errors++;
         $display("FAIL short_pulse_state: got %b, required 0", key_state[3]);
      end
      p = cyc;
      key_raw[3] = 1'b0;
      exp_q.push_back(ev(1, 3, p + 10));
      exp_q.push_back(ev(5, 0, p + 10));
      exp_q.push_back(ev(2, 3, p + 18));
      wait_until(p + 8);
      key_raw[3] = 1'b1;
      wait_until(p + 10);
      checks++;
      if (key_state[3] !== 1'b1) begin
         errors++;
         $display("FAIL min_pulse_state: got %b, required 1", key_state[3]);
      end
      wait_until(p + 18);
      checks++;
      if (key_state[3] !== 1'b0) begin
         errors++;
         $display("FAIL min_release_state: got %b, required 0", key_state[3]);
      end
      wait_until(p + 25);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL threshold_pending: got %0d unseen events (next %h), required 0", exp_q.size(), exp_q[0]);
         exp_q.delete();
      end
   endtask

   task automatic test_simultaneous();
      int p;
      p = cyc;
      key_raw = 4'b0110;
      exp_q.push_back(ev(1, 0, p + 10));
      exp_q.push_back(ev(1, 3, p + 10));
      exp_q.push_back(ev(5, 0, p + 10));
      wait_until(p + 10);
      checks++;
      if (key_press !== 4'b1001 || key_any_press !== 1'b1) begin
         errors++;
         $display("FAIL simul_press: got %b/%b, required 1001/1", key_press, key_any_press);
      end
      wait_until(p + 11);
      checks++;
      if (key_any_press !== 1'b0) begin
         errors++;
         $display("FAIL simul_any_once: got %b, required 0", key_any_press);
      end
      wait_until(p + 20);
      key_raw = 4'b1111;
      exp_q.push_back(ev(2, 0, p + 30));
      exp_q.push_back(ev(2, 3, p + 30));
      wait_until(p + 30);
      checks++;
      if (key_release !== 4'b1001) begin
         errors++;
         $display("FAIL simul_release: got %b, required 1001", key_release);
      end
      wait_until(p + 35);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_pending: got %0d unseen events (next %h), required 0", exp_q.size(), exp_q[0]);
         exp_q.delete();
      end
   endtask

   task automatic test_long_repeat();
      int p;
      p = cyc;
      key_raw[2] = 1'b0;
      exp_q.push_back(ev(1, 2, p + 10));
      exp_q.push_back(ev(5, 0, p + 10));
      exp_q.push_back(ev(3, 2, p + 42));
`ifdef KEY_REPEAT_EN
      for (int r = 1; r <= 8; r++) exp_q.push_back(ev(4, 2, p + 42 + 10 * r));
`endif
      exp_q.push_back(ev(2, 2, p + 132));
      wait_until(p + 41);
      checks++;
      if (key_long !== 4'b0000) begin
         errors++;
         $display("FAIL long_early: got %b, required 0000", key_long);
      end
      wait_until(p + 42);
      checks++;
      if (key_long !== 4'b0100) begin
         errors++;
         $display("FAIL long_pulse: got %b, required 0100", key_long);
      end
      wait_until(p + 52);
      checks++;
      if (key_repeat !== REP_AT_FIRST) begin
         errors++;
         $display("FAIL repeat_first: got %b, required %b", key_repeat, REP_AT_FIRST);
      end
      wait_until(p + 122);
      key_raw[2] = 1'b1;
      wait_until(p + 131);
      checks++;
      if (key_state[2] !== 1'b1) begin
         errors++;
         $display("FAIL long_held_state: got %b, required 1", key_state[2]);
      end
      wait_until(p + 132);
      checks++;
      if (key_state[2] !== 1'b0 || key_release !== 4'b0100 || key_repeat !== 4'b0000) begin
         errors++;
         $display("FAIL long_release: got state %b rel %b rep %b, required 0/0100/0000",
                  key_state[2], key_release, key_repeat);
      end
      wait_until(p + 150);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL long_pending: got %0d unseen events (next %h), required 0", exp_q.size(), exp_q[0]);
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      int p;
      int q;
      p = cyc;
      key_raw[0] = 1'b0;
      exp_q.push_back(ev(1, 0, p + 10));
      exp_q.push_back(ev(5, 0, p + 10));
      wait_until(p + 13);
      key_raw[1] = 1'b0;
      wait_until(p + 19);
      checks++;
      if (key_state !== 4'b0001) begin
         errors++;
         $display("FAIL mid_hold_state: got %b, required 0001", key_state);
      end
      wait_until(p + 20);
      rst_in = 1'b0;
      #1;
      checks++;
      if ({key_state, key_press, key_release, key_long, key_repeat, key_any_press} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b/%b/%b/%b/%b/%b, required all 0",
                  key_state, key_press, key_release, key_long, key_repeat, key_any_press);
      end
      @(negedge sys_clk);
      @(negedge sys_clk);
      q = cyc;
      rst_in = 1'b1;
      exp_q.push_back(ev(1, 0, q + 10));
      exp_q.push_back(ev(1, 1, q + 10));
      exp_q.push_back(ev(5, 0, q + 10));
      wait_until(q + 9);
      checks++;
      if (key_state !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_early: got %b, required 0000", key_state);
      end
      wait_until(q + 10);
      checks++;
      if (key_state !== 4'b0011 || key_press !== 4'b0011) begin
         errors++;
         $display("FAIL post_reset_press: got state %b press %b, required 0011/0011", key_state, key_press);
      end
      wait_until(q + 15);
      key_raw = 4'b1111;
      exp_q.push_back(ev(2, 0, q + 25));
      exp_q.push_back(ev(2, 1, q + 25));
      wait_until(q + 30);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_pending: got %0d unseen events (next %h), required 0", exp_q.size(), exp_q[0]);
         exp_q.delete();
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_threshold();
      test_simultaneous();
      test_long_repeat();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_array_debounce.md
Name: key_array_debounce

Overview:
- Parametrised multi-channel key front end, successor to the single-key debouncer.
- Synchronises, debounces (press and release, symmetric), and classifies N independent keys.
- Per key: stable level, one-cycle press/release/long-press pulses, optional auto-repeat.
- Sits between board push-buttons and the UI/control FSMs on the 27 MHz system clock.

Parameters:
- NUM_KEYS, 4, number of independent key channels (1..16).
- ACTIVE_LOW, 1, 1 = raw key low when pressed, 0 = raw key high when pressed.
- DEBOUNCE_CNT, 540000, consecutive stable cycles required to accept a level change (27 MHz × 20 ms); must be ≥2.
- LONG_CNT, 27000000, cycles of continuous pressed state before the long-press pulse (1 s); must be > 1.
- REPEAT_CNT, 5400000, auto-repeat period in cycles after long press (200 ms); used only with KEY_REPEAT_EN.

Ports:
- sys_clk  input  1  system clock, 27 MHz.
- rst_in  input  1  reset, asynchronous, active-low.
- key_raw  input  NUM_KEYS  raw asynchronous key inputs, polarity per ACTIVE_LOW.
- key_state  output  NUM_KEYS  debounced level, 1 = pressed.
- key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
- key_long  output  NUM_KEYS  one-cycle pulse when held LONG_CNT cycles.
- key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse (0 without KEY_REPEAT_EN).
- key_any_press  output  1  registered OR of key_press, same cycle as key_press.

Behaviour:
- Reset (rst_in low, async): sync flops = released level (ACTIVE_LOW ? 1 : 0); key_state, key_press, key_release, key_long, key_repeat, key_any_press = 0; all counters 0. Mid-operation reset discards in-progress debounce/hold; no pulses on release from reset.
- Per channel, fully independent; no shared counters.
- Sync: two flops per bit; normalised level lvl = sync2 XOR ACTIVE_LOW (1 = pressed).
- Debounce counter, width $clog2(DEBOUNCE_CNT):
  - lvl == key_state: counter cleared to 0.
  - lvl != key_state and counter < DEBOUNCE_CNT-1: increment.
  - lvl != key_state and counter == DEBOUNCE_CNT-1: key_state <= lvl, counter <= 0.
  - Any glitch back to key_state before reaching the threshold restarts the count. Pulses shorter than DEBOUNCE_CNT cycles are never accepted.
- Latency: raw edge to key_state change = 2 sync cycles + DEBOUNCE_CNT cycles.
- key_press/key_release: registered, high exactly in the first cycle key_state shows the new value.
- Hold counter, width $clog2(LONG_CNT+1): cleared while key_state = 0; increments while key_state = 1; saturates at LONG_CNT.
  - key_long pulses once, in the cycle the counter goes LONG_CNT-1 → LONG_CNT. There is no further key_long until release and re-press.
  - Release before LONG_CNT: no key_long.
- Simultaneous events on different channels all pulse in the same cycle. key_any_press follows.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - A per-channel repeat counter, width $clog2(REPEAT_CNT), starts at 0 on the key_long cycle.
  - key_repeat pulses every REPEAT_CNT cycles while key_state = 1. The first pulse comes REPEAT_CNT cycles after key_long.
  - Release clears the repeat counter immediately; no pulse in the release cycle.
- Undefined: repeat logic is absent; key_repeat tied to 0.

Test Plan:
- Params NUM_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CNT=8, LONG_CNT=32, REPEAT_CNT=10. Drive key_raw[0] low and hold → key_state[0] rises 10 cycles after the edge. key_press[0] and key_any_press high for exactly that one cycle. Other channels stay 0.
- Bounce key_raw[1] low 5 cycles, high 1 cycle, low 5 cycles, then high → no key_state/key_press activity on channel 1.
- Hold key_raw[2] pressed, then release → key_long[2] pulses 32 cycles after key_state rise. Release → key_release[2] pulses 10 cycles after the raw rising edge, key_state[2] = 0 in the same cycle.
- Press keys 0 and 3 on the same edge → both key_press bits high in the same cycle; key_any_press single pulse.
- Assert rst_in low mid-debounce (cycle 5 of 8) and mid-hold → all outputs 0 immediately. After reset, a key still held is re-debounced and gives one fresh key_press.
- With KEY_REPEAT_EN, hold 80 cycles past key_long → key_repeat pulses at +10, +20, … +80 (8 pulses); none after release. Without the macro → key_repeat constant 0.
